// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//   Streams a program from a byte source into CPU instruction memory while
//   holding the CPU in reset. After the final byte the CPU stays in reset for
//   RESET_HOLD more cycles and is then released. A program longer than
//   MAX_BYTES is rejected and the CPU is kept in reset.
//
// Parameters
//   MAX_BYTES   maximum program length in bytes (1..256)
//   RESET_HOLD  cycles cpu_reset stays high after the final write (1..15)
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   start                   one-cycle load request (honoured in IDLE/RUN/ERR)
//   src_valid/data/last     byte source; src_ready marks acceptance cycles
//   ins_write / ins_read    instruction-memory write mode and its inverse
//   wr_strobe/addr/data     one-cycle write pulse with address and byte
//   cpu_reset               holds the CPU in reset while high
//   byte_count              bytes written by the current or last load
//   busy / done / error     load status
// ---------------------------------------------------------------------------
module program_loader #(
    parameter int MAX_BYTES  = 256,
    parameter int RESET_HOLD = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       src_valid,
    input  logic [7:0] src_data,
    input  logic       src_last,
    output logic       src_ready,
    output logic       ins_write,
    output logic       ins_read,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       cpu_reset,
    output logic [8:0] byte_count,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam logic [8:0] MAX_CNT   = 9'(MAX_BYTES);
    localparam logic [3:0] HOLD_LAST = 4'(RESET_HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RELEASE,
        S_RUN,
        S_ERR
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] hold_cnt, hold_cnt_nxt;

    // Next values of the registered outputs
    logic       src_ready_nxt, ins_write_nxt, wr_strobe_nxt;
    logic [7:0] wr_addr_nxt, wr_data_nxt;
    logic       cpu_reset_nxt, busy_nxt, done_nxt, error_nxt;
    logic [8:0] byte_count_nxt;

    logic accept;      // byte handshake this cycle
    logic room;        // a further byte still fits
    logic start_load;  // start is honoured in the current state

    // src_ready is a registered copy of (state == S_LOAD), so the state
    // itself can qualify the handshake.
    assign accept     = (state == S_LOAD) && src_valid;
    assign room       = (byte_count < MAX_CNT);
    assign start_load = start && ((state == S_IDLE) || (state == S_RUN) ||
                                  (state == S_ERR));

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            hold_cnt   <= '0;
            src_ready  <= 1'b0;
            ins_write  <= 1'b0;
            ins_read   <= 1'b1;
            wr_strobe  <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            cpu_reset  <= 1'b1;
            byte_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_nxt;
            hold_cnt   <= hold_cnt_nxt;
            src_ready  <= src_ready_nxt;
            ins_write  <= ins_write_nxt;
            ins_read   <= ~ins_write_nxt;
            wr_strobe  <= wr_strobe_nxt;
            wr_addr    <= wr_addr_nxt;
            wr_data    <= wr_data_nxt;
            cpu_reset  <= cpu_reset_nxt;
            byte_count <= byte_count_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            error      <= error_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        unique case (state)
            S_IDLE, S_RUN, S_ERR: begin
                if (start_load)
                    state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (accept) begin
                    if (!room) begin
                        // Overflow wins over src_last: the byte is dropped.
                        state_nxt = S_ERR;
                    end else if (src_last) begin
                        state_nxt    = S_RELEASE;
                        hold_cnt_nxt = '0;
                    end
                end
            end
            S_RELEASE: begin
                if (hold_cnt == HOLD_LAST)
                    state_nxt = S_RUN;
                else
                    hold_cnt_nxt = hold_cnt + 4'd1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic: values the output registers take at the next edge.
    // Status levels follow the state being entered so they change on the
    // same edge as the transition.
    // -----------------------------------------------------------------------
    always_comb begin
        wr_strobe_nxt = accept && room;
        wr_addr_nxt   = wr_strobe_nxt ? byte_count[7:0] : wr_addr;
        wr_data_nxt   = wr_strobe_nxt ? src_data        : wr_data;

        byte_count_nxt = byte_count;
        if (start_load)
            byte_count_nxt = '0;
        else if (wr_strobe_nxt)
            byte_count_nxt = byte_count + 9'd1;

        src_ready_nxt = (state_nxt == S_LOAD);
        // The final write pulse still needs write mode even though the
        // state has already moved on to RELEASE.
        ins_write_nxt = (state_nxt == S_LOAD) || wr_strobe_nxt;
        cpu_reset_nxt = (state_nxt != S_RUN);
        busy_nxt      = (state_nxt == S_LOAD) || (state_nxt == S_RELEASE);
        done_nxt      = (state_nxt == S_RUN);
        error_nxt     = (state_nxt == S_ERR);
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter MAX_BYTES, default 256, meaning the maximum program length in bytes (legal range 1..256).
REQ-002 The block SHALL have parameter RESET_HOLD, default 2, meaning the number of cycles cpu_reset is held after the final write (legal range 1..15).
REQ-003 clk  input  1  single clock; all logic updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin a program load.
REQ-006 src_valid  input  1  the source presents a program byte.
REQ-007 src_data  input  8  program byte.
REQ-008 src_last  input  1  qualifies src_data as the final program byte.
REQ-009 src_ready  output  1  the loader accepts a byte this cycle.
REQ-010 ins_write  output  1  level; instruction-memory write mode to the CPU.
REQ-011 ins_read  output  1  level; always the inverse of ins_write.
REQ-012 wr_strobe  output  1  one-cycle write pulse to instruction memory.
REQ-013 wr_addr  output  8  instruction-memory address for wr_strobe.
REQ-014 wr_data  output  8  instruction byte for wr_strobe.
REQ-015 cpu_reset  output  1  holds the CPU in reset while high.
REQ-016 byte_count  output  9  number of bytes written in the current or last load.
REQ-017 busy  output  1  a load or release is in progress.
REQ-018 done  output  1  the last load completed and the CPU is released.
REQ-019 error  output  1  the last load overflowed MAX_BYTES.

Function
REQ-020 The FSM SHALL have states IDLE, LOAD, RELEASE, RUN, ERR; all outputs SHALL be registered.
REQ-021 In IDLE, RUN, or ERR, start SHALL move the FSM to LOAD on the next edge and, in that same edge, clear byte_count, done, and error and set cpu_reset=1, ins_write=1, busy=1.
REQ-022 In LOAD and RELEASE, start SHALL be ignored.
REQ-023 src_ready SHALL be 1 exactly while the state is LOAD; a byte is accepted on any edge where src_valid=1 and src_ready=1; back-to-back acceptance every cycle SHALL be supported.
REQ-024 A byte accepted at edge N with byte_count<MAX_BYTES SHALL produce, from edge N for exactly one cycle, wr_strobe=1, wr_addr=byte_count[7:0] (pre-increment), and wr_data=src_data; byte_count SHALL increment at that same edge.
REQ-025 wr_addr and wr_data SHALL hold their last values when wr_strobe=0.
REQ-026 If the accepted byte has src_last=1 and is written, the FSM SHALL enter RELEASE at the same edge.
REQ-027 ins_write SHALL equal 1 while the state is LOAD or while wr_strobe=1, and 0 otherwise.
REQ-028 RELEASE SHALL last exactly RESET_HOLD cycles, with cpu_reset=1 and busy=1 throughout.
REQ-029 On leaving RELEASE, the FSM SHALL enter RUN with cpu_reset=0, busy=0, done=1, and SHALL stay in RUN until start or reset.
REQ-030 An accepted byte when byte_count==MAX_BYTES (overflow) SHALL NOT be written, even if src_last=1; the FSM SHALL enter ERR with error=1, busy=0, cpu_reset=1, and ins_write=0.
REQ-031 In ERR, cpu_reset SHALL remain 1 until start or reset.
REQ-032 byte_count SHALL saturate at MAX_BYTES; a 256-byte program SHALL write addresses 0..255 with no address wrap.
REQ-033 src_valid=1 together with src_last=1 in a cycle where src_ready=0 SHALL have no effect.

Reset
REQ-034 On reset, the FSM SHALL enter IDLE with src_ready=0, ins_write=0, ins_read=1, wr_strobe=0, wr_addr=0, wr_data=0, byte_count=0, cpu_reset=1, busy=0, done=0, error=0.
REQ-035 Reset SHALL take priority over start and over byte acceptance, including mid-LOAD and mid-RELEASE; a partial load SHALL be abandoned with no further wr_strobe.

Verification
REQ-036 Default parameters; start, then bytes 0x11, 0x22, 0x33 (last) on consecutive cycles -> three wr_strobe pulses at addresses 0, 1, 2 with data 0x11, 0x22, 0x33; byte_count=3; cpu_reset high for 2 cycles after the final strobe edge; then done=1 and cpu_reset=0.
REQ-037 Toggle src_valid every other cycle during LOAD -> wr_strobe pulses only on accepting edges, with contiguous addresses and no duplicates.
REQ-038 MAX_BYTES=4; send 5 bytes, the 5th with last -> 4 writes, 5th not written; error=1, byte_count=4, cpu_reset=1, done=0.
REQ-039 Assert reset after the 2nd accepted byte -> IDLE, all outputs at reset values, no further wr_strobe; a following start reloads from address 0.
REQ-040 Start pulsed in LOAD -> ignored, byte_count not cleared; start pulsed in RUN -> new load, done=0, cpu_reset=1 on the next cycle.
REQ-041 MAX_BYTES=256; send 256 bytes, the final one with last -> final wr_addr=0xFF, byte_count=256, done=1, error=0.
